// File: rtl/conv2d_rmem_if.sv
// conv2d_rmem_if: read-master control and user-buffer port bundle.
// master modport = pixel fetcher side, slave modport = read-master side.
interface conv2d_rmem_if #(
    parameter int AW = 30,
    parameter int DW = 256
);
    logic          rmst_ctrl_fixed_location;
    logic [AW-1:0] rmst_ctrl_read_base;
    logic [AW-1:0] rmst_ctrl_read_length;
    logic          rmst_ctrl_go;
    logic          rmst_ctrl_done;
    logic          rmst_user_read_buffer;
    logic [DW-1:0] rmst_user_buffer_output_data;
    logic          rmst_user_data_available;

    modport master (
        output rmst_ctrl_fixed_location,
        output rmst_ctrl_read_base,
        output rmst_ctrl_read_length,
        output rmst_ctrl_go,
        input  rmst_ctrl_done,
        output rmst_user_read_buffer,
        input  rmst_user_buffer_output_data,
        input  rmst_user_data_available
    );

    modport slave (
        input  rmst_ctrl_fixed_location,
        input  rmst_ctrl_read_base,
        input  rmst_ctrl_read_length,
        input  rmst_ctrl_go,
        output rmst_ctrl_done,
        input  rmst_user_read_buffer,
        output rmst_user_buffer_output_data,
        output rmst_user_data_available
    );
endinterface

// File: rtl/conv2d_rmem.sv
// conv2d_rmem: fetches length_in 32-bit pixels from memory through a burst
// read master (bursts of up to 4 x 128-bit beats) and unpacks each beat into
// a valid/ready pixel stream, lane 0 first.
// Optional: define CONV2D_RMEM_STAT_EN to add the stat_stall counter output.
module conv2d_rmem #(
    parameter int AW = 30,
    parameter int DW = 256
) (
    input  logic              clk,
    input  logic              rst,
    conv2d_rmem_if.master     rmst,
    input  logic              param_ena,
    input  logic [AW-1:0]     param_xaddr,
    input  logic [17:0]       param_length_in,
    output logic              pxl_vld_x,
    output logic [31:0]       pxl_x,
    input  logic              pxl_rdy_x,
    output logic              flag_read_over
`ifdef CONV2D_RMEM_STAT_EN
    ,
    output logic [31:0]       stat_stall
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DRAIN} state_t;

    state_t        state_q, state_d;

    logic          ena_q, done_q;
    logic [17:0]   len_q, total_beats_q, beats_req_q, beats_pop_q, pix_cnt_q;
    logic [AW-1:0] addr_q, base_q, rlen_q;
    logic          go_q;
    logic [127:0]  hold_q;
    logic          vld_q;
    logic [1:0]    idx_q;
    logic          flag_q;

    logic          start, done_rise, xfer, at_last, pop;
    logic [17:0]   total_beats_in;
    logic [1:0]    last_lane;
    logic          issue;
    logic [17:0]   remaining;
    logic [2:0]    burst_beats;
    logic          flag_d;
    logic          unused_hi;

    assign start          = param_ena & ~ena_q & (state_q == ST_IDLE);
    assign done_rise      = rmst.rmst_ctrl_done & ~done_q;
    assign total_beats_in = 18'((19'(param_length_in) + 19'd3) >> 2);

    // The held beat is the final one once every beat of the job has been popped
    assign last_lane = (beats_pop_q == total_beats_q) ? (len_q[1:0] - 2'd1) : 2'd3;
    assign xfer      = vld_q & pxl_rdy_x;
    assign at_last   = xfer & (idx_q == last_lane);
    assign pop       = rmst.rmst_user_data_available & (beats_pop_q < total_beats_q)
                       & (~vld_q | at_last);

    assign rmst.rmst_ctrl_fixed_location = 1'b0;
    assign rmst.rmst_ctrl_read_base      = base_q;
    assign rmst.rmst_ctrl_read_length    = rlen_q;
    assign rmst.rmst_ctrl_go             = go_q;
    assign rmst.rmst_user_read_buffer    = pop;

    assign pxl_vld_x      = vld_q;
    assign pxl_x          = hold_q[{idx_q, 5'd0} +: 32];
    assign flag_read_over = flag_q;

    assign unused_hi = ^rmst.rmst_user_buffer_output_data[DW-1:128];

    // Edge-detect history; ena_q resets high so a level already present at
    // release is not mistaken for a new trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            ena_q  <= param_ena;
            done_q <= rmst.rmst_ctrl_done;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = (total_beats_in == 18'd0) ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_rise) state_d = (beats_req_q < total_beats_q) ? ST_ISSUE : ST_DRAIN;
            ST_DRAIN: if (pix_cnt_q == len_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: burst issue strobe, burst size, job-complete strobe
    always_comb begin
        issue       = 1'b0;
        flag_d      = 1'b0;
        remaining   = total_beats_q - beats_req_q;
        burst_beats = (remaining >= 18'd4) ? 3'd4 : remaining[2:0];
        if (state_q == ST_ISSUE) issue = 1'b1;
        if ((xfer && ((pix_cnt_q + 18'd1) == len_q)) ||
            (start && (param_length_in == 18'd0)))
            flag_d = 1'b1;
    end

    // Job latch and burst command registers (held until the next go)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_q          <= 1'b0;
            addr_q        <= '0;
            base_q        <= '0;
            rlen_q        <= '0;
            len_q         <= '0;
            total_beats_q <= '0;
            beats_req_q   <= '0;
        end else begin
            go_q <= issue;
            if (start) begin
                addr_q        <= param_xaddr;
                len_q         <= param_length_in;
                total_beats_q <= total_beats_in;
                beats_req_q   <= '0;
            end else if (issue) begin
                base_q      <= addr_q;
                rlen_q      <= AW'(burst_beats) << 4;
                addr_q      <= addr_q + AW'(64);
                beats_req_q <= beats_req_q + 18'(burst_beats);
            end
        end
    end

    // Beat unpacker: a fresh beat replaces the held one in the same cycle its
    // last used lane transfers, so the stream can run without bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            vld_q       <= 1'b0;
            idx_q       <= '0;
            beats_pop_q <= '0;
            pix_cnt_q   <= '0;
            flag_q      <= 1'b0;
        end else begin
            flag_q <= flag_d;
            if (start) begin
                vld_q       <= 1'b0;
                idx_q       <= '0;
                beats_pop_q <= '0;
                pix_cnt_q   <= '0;
            end else begin
                if (xfer) pix_cnt_q <= pix_cnt_q + 18'd1;
                if (pop) begin
                    hold_q      <= rmst.rmst_user_buffer_output_data[127:0];
                    vld_q       <= 1'b1;
                    idx_q       <= '0;
                    beats_pop_q <= beats_pop_q + 18'd1;
                end else if (at_last) begin
                    vld_q <= 1'b0;
                end else if (xfer) begin
                    idx_q <= idx_q + 2'd1;
                end
            end
        end
    end

`ifdef CONV2D_RMEM_STAT_EN
    // Saturating count of cycles the downstream holds off a valid pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      stat_stall <= '0;
        else if (start)                               stat_stall <= '0;
        else if (vld_q && !pxl_rdy_x && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
`endif

endmodule
